pwm_audio_dac: RTL
==================

// Module: pwm_audio_dac
// PURPOSE
//   Downstream consumer of the NCO: pulls one sample per PWM window via a next_sample
//   pulse and converts the offset-binary code into a PWM bitstream for the audio pin.
//   Adds enable/drain sequencing, mute and 3-bit attenuation applied around mid-scale.
//   Sits between the NCO (code/next_sample) and the board audio output.
// PARAMETERS
//   CODE_WIDTH         10    sample width; offset-binary, mid-scale MID = 2**(CODE_WIDTH-1)
//   CYCLES_PER_WINDOW  1024  clocks per PWM window; must equal 2**CODE_WIDTH
// PORTS
//   clk          in   1           system clock (125 MHz)
//   rst          in   1           synchronous, active-high reset
//   enable       in   1           1 = fetch and play samples; 0 = park output at mid-scale
//   mute         in   1           1 = play mid-scale; sample fetching continues
//   volume       in   3           attenuation: arithmetic right-shift of (code - MID)
//   code         in   CODE_WIDTH  NCO output sample
//   next_sample  out  1           one-cycle request to NCO to advance
//   pwm          out  1           PWM bitstream
// BEHAVIOUR
//   - Reset (sync): cnt=0, duty=MID, state=IDLE, next_sample=0, pwm=0 while rst high.
//   - cnt counts 0..W-1 and wraps; "boundary" = edge where cnt goes W-1 -> 0.
//   - States: IDLE, RUN, DRAIN.
//     IDLE : no requests; duty=MID. enable=1 -> RUN at the next boundary (windows stay aligned).
//     RUN  : next_sample=1 for exactly the cycle cnt==W-2; NCO updates code on that edge;
//            code is stable during cnt==W-1 and is loaded into duty at the boundary.
//            enable=0 -> DRAIN on the next edge.
//     DRAIN: no new requests. If a request already fired this window its sample is still
//            loaded at the boundary and played for one window, then duty=MID at the following
//            boundary -> IDLE. If no request fired, duty=MID at the boundary -> IDLE.
//            enable=1 in DRAIN -> RUN next edge; requests resume in the same window.
//   - Load latency: request at cnt W-2, duty valid from cnt 0 (2 cycles); pwm is registered.
//   - Duty arithmetic at boundary (mute/volume sampled only there, never mid-window):
//     s = $signed({1'b0,code}) - MID (CODE_WIDTH+1 bits); duty = MID + (s >>> volume);
//     mute=1 -> duty=MID. Result always within [0, W-1]; no saturation logic needed.
//   - pwm (edge-aligned default): pwm <= (cnt < duty); high time = duty clocks per window;
//     code 0 -> always low, code W-1 -> low for one clock.
//   - Simultaneous rst with anything: rst wins. Reset mid-window restarts at cnt=0, IDLE.
// CONFIGURATION
//   PWM_DAC_CENTER_ALIGNED_EN defined: pwm high for cnt in [start, start+duty) with
//   start = (W - duty) >> 1 (pulse centred in window; same high count, same latency).
//   Not defined: edge-aligned, pwm high for cnt in [0, duty).
// STRUCTURE
//   - pwm_dac_defs.vh: state localparams IDLE/RUN/DRAIN, MID, W-derived constants.
//   - Sub-module pwm_dac_duty_calc: combinational code/mute/volume -> duty (unit-testable).
//   - Top: window counter, FSM, duty register, pwm comparator register.
// TESTING (W=1024, CODE_WIDTH=10, code driven by stub NCO model)
//   1 rst 3 cycles, enable=0 -> next_sample never pulses; pwm high 512 clocks/window.
//   2 enable=1, stub code=768 -> next_sample one pulse at cnt 1022 each window;
//     next window pwm high count = 768; pulse spacing exactly 1024 cycles.
//   3 volume=1, code=768 -> 640; code=0, volume=1 -> 256; code=1023, volume=7 -> 515.
//   4 mute=1 mid-window, code=900 -> current window unchanged, then 512 high/window; pulses continue.
//   5 enable=0 at cnt 100 (no request yet this window) -> no pulse at 1022; next window 512; IDLE;
//     enable=0 at cnt 1023 (after request) -> one more window at fetched code, then 512.
//   6 rst at cnt 500 in RUN -> pwm=0 during rst; after release cnt=0, IDLE, duty=512;
//     with PWM_DAC_CENTER_ALIGNED_EN, code=768 -> pwm high exactly for cnt 128..895.

Source files
------------

// File: rtl/pwm_audio_dac_pkg.sv
// rtl/pwm_audio_dac_pkg.sv - state encoding and default width for the PWM audio DAC
package pwm_audio_dac_pkg;

  localparam int DEFAULT_CODE_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dac_state_t;

endpackage

// File: rtl/pwm_dac_duty_calc.sv
// rtl/pwm_dac_duty_calc.sv - combinational offset-binary code to duty with mute and attenuation
module pwm_dac_duty_calc
  import pwm_audio_dac_pkg::*;
#(
  parameter int CODE_WIDTH = DEFAULT_CODE_WIDTH
) (
  input  logic [CODE_WIDTH-1:0] code,
  input  logic                  mute,
  input  logic [2:0]            volume,
  output logic [CODE_WIDTH-1:0] duty
);

  localparam logic signed [CODE_WIDTH:0] MID_S = (CODE_WIDTH+1)'(2**(CODE_WIDTH-1));

  logic signed [CODE_WIDTH:0] offset;
  logic signed [CODE_WIDTH:0] scaled;
  logic signed [CODE_WIDTH:0] level;
  logic                       level_msb_unused;

  // Shifting the signed offset keeps the result inside [0, 2*MID-1] for any volume.
  always_comb begin
    offset = $signed({1'b0, code}) - MID_S;
    scaled = offset >>> volume;
    level  = scaled + MID_S;
    duty   = mute ? MID_S[CODE_WIDTH-1:0] : level[CODE_WIDTH-1:0];
  end

  assign level_msb_unused = level[CODE_WIDTH];

endmodule

// File: rtl/pwm_audio_dac.sv
// rtl/pwm_audio_dac.sv - windowed PWM audio DAC with enable/drain sequencing, mute and attenuation
// Optional: PWM_DAC_CENTER_ALIGNED_EN centres the pulse in the window (default edge-aligned).
module pwm_audio_dac
  import pwm_audio_dac_pkg::*;
#(
  parameter int CODE_WIDTH        = DEFAULT_CODE_WIDTH,
  parameter int CYCLES_PER_WINDOW = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mute,
  input  logic [2:0]            volume,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm
);

  localparam logic [CODE_WIDTH-1:0] MID      = CODE_WIDTH'(2**(CODE_WIDTH-1));
  localparam logic [CODE_WIDTH-1:0] CNT_LAST = CODE_WIDTH'(CYCLES_PER_WINDOW-1);
  localparam logic [CODE_WIDTH-1:0] CNT_REQ  = CODE_WIDTH'(CYCLES_PER_WINDOW-2);

  dac_state_t            state, state_n;
  logic [CODE_WIDTH-1:0] cnt, cnt_n;
  logic [CODE_WIDTH-1:0] duty, duty_n;
  logic [CODE_WIDTH-1:0] calc_duty;
  logic                  req_fired;
  logic                  boundary;
  logic                  pwm_n;

  pwm_dac_duty_calc #(
    .CODE_WIDTH(CODE_WIDTH)
  ) u_duty_calc (
    .code  (code),
    .mute  (mute),
    .volume(volume),
    .duty  (calc_duty)
  );

  assign cnt_n       = cnt + CODE_WIDTH'(1);
  assign boundary    = (cnt == CNT_LAST);
  assign next_sample = !rst && (state == RUN) && (cnt == CNT_REQ);

  always_comb begin
    state_n = state;
    duty_n  = duty;
    case (state)
      IDLE: begin
        if (boundary && enable) state_n = RUN;
      end
      RUN: begin
        if (boundary) duty_n = req_fired ? calc_duty : MID;
        if (!enable) state_n = DRAIN;
      end
      DRAIN: begin
        // A sample fetched before the drain still plays for one full window.
        if (boundary) duty_n = req_fired ? calc_duty : MID;
        if (enable) state_n = RUN;
        else if (boundary && !req_fired) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        duty_n  = MID;
      end
    endcase
  end

  // The comparator looks at next-cycle count/duty so the registered pwm lines up with cnt.
`ifdef PWM_DAC_CENTER_ALIGNED_EN
  localparam logic [CODE_WIDTH:0] WINDOW = (CODE_WIDTH+1)'(CYCLES_PER_WINDOW);

  logic [CODE_WIDTH:0] pulse_start;
  logic [CODE_WIDTH:0] pulse_stop;

  always_comb begin
    pulse_start = (WINDOW - {1'b0, duty_n}) >> 1;
    pulse_stop  = pulse_start + {1'b0, duty_n};
    pwm_n       = ({1'b0, cnt_n} >= pulse_start) && ({1'b0, cnt_n} < pulse_stop);
  end
`else
  always_comb begin
    pwm_n = (cnt_n < duty_n);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      state     <= IDLE;
      duty      <= MID;
      req_fired <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      state <= state_n;
      duty  <= duty_n;
      pwm   <= pwm_n;
      if (boundary)         req_fired <= 1'b0;
      else if (next_sample) req_fired <= 1'b1;
    end
  end

endmodule
